// File: rtl/riscv_irq_ctrl.sv
// Edge-latching, fixed-priority interrupt controller for a single I_Req/IACK core handshake.
// MASK/PENDING/ID/EOI are memory-mapped in a 16-byte window on the core data port.
module riscv_irq_ctrl #(
  parameter int unsigned NUM_SRC   = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int unsigned ID_W      = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [31:0]        Data_addr,
  input  logic [31:0]        Wdata,
  input  logic [3:0]         we,
  output logic [31:0]        Rdata,
  output logic               sel,
  output logic               I_Req,
  input  logic               IACK,
  output logic [ID_W-1:0]    irq_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_e;

  state_e             state_q;
  logic               ireq_q;
  logic [ID_W-1:0]    id_q;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] prev_q;

  logic [31:0]        off_s;
  logic [31:0]        lane_s;
  logic               wr_s, wr_mask_s, wr_pend_s, wr_eoi_s;
  logic [NUM_SRC-1:0] rise_s, cand_s, id_oh_s, wbits_s;
  logic [ID_W-1:0]    win_s;
  logic               ack_s, hold_s;
  logic               unused_s;

  // Offset wraps below BASE_ADDR, so a single unsigned compare bounds the window.
  assign off_s     = Data_addr - BASE_ADDR;
  assign sel       = (off_s < 32'd16);
  assign lane_s    = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  assign wr_s      = sel && (we != 4'd0);
  assign wr_mask_s = wr_s && (off_s[3:2] == 2'd0);
  assign wr_pend_s = wr_s && (off_s[3:2] == 2'd1);
  assign wr_eoi_s  = wr_s && (off_s[3:2] == 2'd3);
  assign wbits_s   = Wdata[NUM_SRC-1:0] & lane_s[NUM_SRC-1:0];

  assign rise_s    = irq_src & ~prev_q;
  assign cand_s    = pend_q & mask_q;
  assign id_oh_s   = NUM_SRC'(1) << id_q;
  assign ack_s     = (state_q == REQ) && IACK;
  assign hold_s    = |(cand_s & id_oh_s);

  assign I_Req     = ireq_q;
  assign irq_id    = id_q;
  assign unused_s  = ^{Wdata, lane_s};

  // Register read mux, side-effect free.
  always_comb begin
    Rdata = 32'd0;
    if (sel) begin
      case (off_s[3:2])
        2'd0:    Rdata = 32'(mask_q);
        2'd1:    Rdata = 32'(pend_q);
        2'd2:    Rdata = 32'({(state_q == SVC), id_q});
        default: Rdata = 32'd0;
      endcase
    end else begin
      Rdata = 32'd0;
    end
  end

  // Lowest set candidate index wins.
  always_comb begin
    win_s = {ID_W{1'b0}};
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand_s[i]) begin
        win_s = ID_W'(i);
      end else begin
        win_s = win_s;
      end
    end
  end

  // Next MASK/PENDING: new edges are OR-ed last so they beat W1C and ack-clear.
  always_comb begin
    mask_d = mask_q;
    pend_d = pend_q;
    if (wr_mask_s) begin
      mask_d = (mask_q & ~lane_s[NUM_SRC-1:0]) | wbits_s;
    end else begin
      mask_d = mask_q;
    end
    if (wr_pend_s) begin
      pend_d = pend_q & ~wbits_s;
    end else begin
      pend_d = pend_q;
    end
    if (ack_s) begin
      pend_d = pend_d & ~id_oh_s;
    end else begin
      pend_d = pend_d;
    end
    pend_d = pend_d | rise_s;
  end

  // Source history and software-visible registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= {NUM_SRC{1'b0}};
      mask_q <= {NUM_SRC{1'b0}};
      pend_q <= {NUM_SRC{1'b0}};
    end else begin
      prev_q <= irq_src;
      mask_q <= mask_d;
      pend_q <= pend_d;
    end
  end

  // Request/service FSM; the ID is cleared whenever the FSM returns to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ireq_q  <= 1'b0;
      id_q    <= {ID_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (|cand_s) begin
            id_q    <= win_s;
            ireq_q  <= 1'b1;
            state_q <= REQ;
          end else begin
            ireq_q  <= 1'b0;
          end
        end
        REQ: begin
          if (IACK) begin
            ireq_q  <= 1'b0;
            state_q <= SVC;
          end else if (!hold_s) begin
            ireq_q  <= 1'b0;
            id_q    <= {ID_W{1'b0}};
            state_q <= IDLE;
          end else begin
            ireq_q  <= 1'b1;
          end
        end
        SVC: begin
          ireq_q <= 1'b0;
          if (wr_eoi_s) begin
            id_q    <= {ID_W{1'b0}};
            state_q <= IDLE;
          end else begin
            state_q <= SVC;
          end
        end
        default: begin
          ireq_q  <= 1'b0;
          id_q    <= {ID_W{1'b0}};
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_irq_ctrl.sv
// Directed bench for riscv_irq_ctrl with a per-cycle reference model and literal spot checks.
module tb_riscv_irq_ctrl;
  localparam int          NUM_SRC = 8;
  localparam int          ID_W    = 5;
  localparam logic [31:0] BASE    = 32'hFFFF_0000;

  logic            clk       = 1'b0;
  logic            reset     = 1'b1;
  logic [7:0]      irq_src   = 8'd0;
  logic [31:0]     Data_addr = 32'd0;
  logic [31:0]     Wdata     = 32'd0;
  logic [3:0]      we        = 4'd0;
  logic            IACK      = 1'b0;
  logic [31:0]     Rdata;
  logic            sel;
  logic            I_Req;
  logic [ID_W-1:0] irq_id;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: mode 0 = idle, 1 = requesting, 2 = in service
  logic [7:0] m_mask, m_pend, m_prev;
  int         m_mode, m_id;

  riscv_irq_ctrl #(.NUM_SRC(NUM_SRC), .BASE_ADDR(BASE), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .Data_addr(Data_addr),
    .Wdata(Wdata), .we(we), .Rdata(Rdata), .sel(sel), .I_Req(I_Req),
    .IACK(IACK), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_mask = 8'd0; m_pend = 8'd0; m_prev = 8'd0; m_mode = 0; m_id = 0;
  endtask

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (off > 32'd15) return 32'd0;
    case (off[3:2])
      2'd0:    return {24'd0, m_mask};
      2'd1:    return {24'd0, m_pend};
      2'd2:    return ((m_mode == 2) ? 32'h20 : 32'h0) | 32'(m_id);
      default: return 32'd0;
    endcase
  endfunction

  // One clock of the rules, applied to the inputs present at the edge.
  task automatic m_step();
    logic [7:0]  rise, wb, cand, npend, nmask;
    logic [31:0] off, lanes;
    logic        wr;
    rise  = irq_src & ~m_prev;
    m_prev = irq_src;
    off   = Data_addr - BASE;
    lanes = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    wr    = (off < 32'd16) && (we != 4'd0);
    wb    = Wdata[7:0] & lanes[7:0];
    nmask = m_mask;
    npend = m_pend;
    if (wr && off[3:2] == 2'd0) nmask = (m_mask & ~lanes[7:0]) | wb;
    if (wr && off[3:2] == 2'd1) npend = npend & ~wb;
    cand = m_pend & m_mask;
    case (m_mode)
      0: begin
        if (cand != 8'd0) begin
          for (int i = 7; i >= 0; i--) if (cand[i]) m_id = i;
          m_mode = 1;
        end
      end
      1: begin
        if (IACK) begin
          npend[m_id] = 1'b0;
          m_mode = 2;
        end else if (!cand[m_id]) begin
          m_mode = 0;
          m_id = 0;
        end
      end
      2: begin
        if (wr && off[3:2] == 2'd3) begin
          m_mode = 0;
          m_id = 0;
        end
      end
      default: m_mode = 0;
    endcase
    m_pend = npend | rise;
    m_mask = nmask;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) m_reset(); else m_step();
    #1;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] lanes);
    Data_addr = BASE + 32'(off);
    Wdata = d;
    we = lanes;
    tick();
    we = 4'd0;
    Wdata = 32'd0;
  endtask

  task automatic rd(input string name, input logic [3:0] off, input logic [31:0] exp);
    Data_addr = BASE + 32'(off);
    #1;
    chk(name, Rdata, exp);
  endtask

  task automatic pulse(input logic [7:0] v);
    irq_src = v;
    tick();
    irq_src = 8'd0;
  endtask

  task automatic ack();
    IACK = 1'b1;
    tick();
    IACK = 1'b0;
  endtask

  // Per-cycle comparison against the model, half a cycle after each edge.
  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("cyc_ireq", 32'(I_Req), (m_mode == 1) ? 32'd1 : 32'd0);
        chk("cyc_id", 32'(irq_id), 32'(m_id));
        chk("cyc_sel", 32'(sel), (Data_addr - BASE < 32'd16) ? 32'd1 : 32'd0);
        chk("cyc_rdata", Rdata, m_rd(Data_addr));
      end
    end
  end

  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ireq", 32'(I_Req), 32'd0);
    chk("rst_id", 32'(irq_id), 32'd0);
    rd("rst_mask", 4'h0, 32'd0);
    rd("rst_pend", 4'h4, 32'd0);

    // 1: single source, two-cycle latency, ack, ID shows in-service
    wr(4'h0, 32'h01, 4'hF);
    pulse(8'h01);
    chk("t1_ireq_k", 32'(I_Req), 32'd0);
    rd("t1_pend_k", 4'h4, 32'h01);
    tick();
    chk("t1_ireq_k1", 32'(I_Req), 32'd1);
    chk("t1_id", 32'(irq_id), 32'd0);
    ack();
    chk("t1_ireq_ack", 32'(I_Req), 32'd0);
    rd("t1_pend_ack", 4'h4, 32'd0);
    rd("t1_idreg", 4'h8, 32'h20);
    wr(4'hC, 32'h0, 4'hF);
    rd("t1_idreg_eoi", 4'h8, 32'h0);

    // 2: simultaneous edges, priority, re-request after EOI
    wr(4'h0, 32'hFF, 4'hF);
    pulse(8'h24);
    tick();
    chk("t2_ireq", 32'(I_Req), 32'd1);
    chk("t2_id", 32'(irq_id), 32'd2);
    ack();
    wr(4'hC, 32'h0, 4'hF);
    chk("t2_gap", 32'(I_Req), 32'd0);
    tick();
    chk("t2_rereq", 32'(I_Req), 32'd1);
    chk("t2_id5", 32'(irq_id), 32'd5);
    ack();
    wr(4'hC, 32'h0, 4'hF);
    tick();

    // 3: no preemption while requesting
    pulse(8'h20);
    tick();
    pulse(8'h02);
    tick();
    chk("t3_frozen", 32'(irq_id), 32'd5);
    rd("t3_pend", 4'h4, 32'h22);
    ack();
    rd("t3_pend_ack", 4'h4, 32'h02);
    rd("t3_idreg", 4'h8, 32'h25);
    wr(4'hC, 32'h0, 4'hF);
    tick();
    chk("t3_next", 32'(irq_id), 32'd1);
    ack();
    wr(4'hC, 32'h0, 4'hF);
    tick();

    // 4: W1C withdraws the request
    pulse(8'h08);
    tick();
    chk("t4_id3", 32'(irq_id), 32'd3);
    wr(4'h4, 32'h08, 4'hF);
    tick();
    chk("t4_withdraw", 32'(I_Req), 32'd0);
    rd("t4_idreg", 4'h8, 32'h0);

    // 5: edge during service is only recorded
    pulse(8'h10);
    tick();
    ack();
    pulse(8'h10);
    tick();
    rd("t5_pend", 4'h4, 32'h10);
    chk("t5_noreq", 32'(I_Req), 32'd0);
    wr(4'hC, 32'h0, 4'hF);
    tick();
    chk("t5_rereq", 32'(I_Req), 32'd1);
    chk("t5_id", 32'(irq_id), 32'd4);
    ack();
    wr(4'hC, 32'h0, 4'hF);
    tick();

    // Byte lanes and window decode
    wr(4'h0, 32'h0, 4'b0010);
    rd("lane_hi", 4'h0, 32'hFF);
    wr(4'h0, 32'hFFFF_FF0F, 4'b0001);
    rd("lane_lo", 4'h0, 32'h0F);
    Data_addr = BASE + 32'd16;
    #1;
    chk("sel_above", 32'(sel), 32'd0);
    chk("rd_above", Rdata, 32'd0);
    Data_addr = BASE - 32'd4;
    #1;
    chk("sel_below", 32'(sel), 32'd0);
    tick();

    // Masking withdraws; IACK outside REQ ignored; set beats W1C
    pulse(8'h04);
    tick();
    chk("mw_req", 32'(I_Req), 32'd1);
    wr(4'h0, 32'h00, 4'hF);
    tick();
    chk("mw_drop", 32'(I_Req), 32'd0);
    ack();
    rd("mw_pend", 4'h4, 32'h04);
    irq_src = 8'h40;
    wr(4'h4, 32'h44, 4'hF);
    irq_src = 8'h00;
    rd("set_beats_w1c", 4'h4, 32'h40);
    wr(4'h4, 32'hFF, 4'hF);

    // 6: asynchronous reset mid-request
    wr(4'h0, 32'h01, 4'hF);
    pulse(8'h01);
    tick();
    chk("t6_req", 32'(I_Req), 32'd1);
    reset = 1'b1;
    m_reset();
    #1;
    chk("t6_ireq", 32'(I_Req), 32'd0);
    chk("t6_id", 32'(irq_id), 32'd0);
    rd("t6_mask", 4'h0, 32'd0);
    tick();
    reset = 1'b0;
    pulse(8'h01);
    tick();
    chk("t6_masked", 32'(I_Req), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
